// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity-protected byte link.
//   rx_state_e   : receiver FSM states (2-bit encoding)
//   ERR_CNT_MAX  : saturation value of the receiver error counter
//   CALC_MAX_W   : widest word accepted by calc_parity
//   calc_parity  : reduction-XOR parity with odd/even selection, also used by
//                  the transmit-side generators
// Configuration macro referenced by users of this package: PARITY_RX_ERR_CNT_EN
// ---------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;
    localparam int unsigned CALC_MAX_W  = 64;

    // Callers zero-extend narrower words; zero padding does not change the XOR.
    function automatic logic calc_parity(input logic [CALC_MAX_W-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// ---------------------------------------------------------------------------
// parity_calc
// Combinational parity of a DATA_W-bit word (DATA_W <= 64).
//   data_i   in  DATA_W  word to protect
//   parity_o out 1       ^data_i when ODD_PARITY=0, ~^data_i when ODD_PARITY=1
// Configuration macro: none (PARITY_RX_ERR_CNT_EN lives in parity_frame_rx).
// ---------------------------------------------------------------------------
module parity_calc
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);

    logic [CALC_MAX_W-1:0] data_ext;

    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = data_i;
        parity_o               = calc_parity(data_ext, ODD_PARITY);
    end

endmodule

// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
// Receiver for the parity-protected serial byte link. Deserialises a strobed
// frame (start 0, DATA_W data bits LSB first, parity, stop 1), checks parity
// and stop bit, and presents the word with a one-cycle valid pulse.
//   clk         in   1       clock, all state on posedge
//   rst_n       in   1       asynchronous active-low reset
//   rx_bit      in   1       serial line, idles at 1
//   rx_bit_en   in   1       sample strobe; line only consumed when 1
//   data_out    out  DATA_W  last received word, held until next frame ends
//   data_valid  out  1       one-cycle pulse per completed frame
//   parity_err  out  1       qualified by data_valid: parity mismatch
//   frame_err   out  1       qualified by data_valid: stop bit sampled 0
//   err_cnt     out  8       saturating count of errored frames
// Configuration macro: PARITY_RX_ERR_CNT_EN
//   defined   : err_cnt counts frames with parity_err|frame_err, sticks at FF
//   undefined : no counter, err_cnt tied to 8'h00
// ---------------------------------------------------------------------------
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic              par_rx_q,  par_rx_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              valid_q,   valid_d;
    logic              perr_q,    perr_d;
    logic              ferr_q,    ferr_d;
    logic              exp_par;

    parity_calc #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_parity_calc (
        .data_i   (shift_q),
        .parity_o (exp_par)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_rx_d  = par_rx_q;
        data_d    = data_q;
        // valid and flags are pulses: they fall every cycle, even between strobes
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (rx_bit_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d[bit_cnt_q] = rx_bit;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    par_rx_d = rx_bit;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = par_rx_q ^ exp_par;
                    ferr_d  = ~rx_bit;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_rx_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_rx_q  <= par_rx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

`ifdef PARITY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (valid_q && (perr_q || ferr_q) && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule
